lsu_align_unit: RTL

Load/store alignment unit between the execute/memory pipeline register and `data_memory`. Aligned accesses pass straight through in one cycle. Misaligned loads and stores are split into a short sequence of legal accesses while the upstream pipeline is stalled:

- a misaligned `lw`/`lh`/`lhu` becomes two word reads, merged into one result;
- a misaligned `sw`/`sh` becomes 2 or 4 byte stores.

---
 rtl/lsu_align_unit_if.sv | 31 +++
 rtl/lsu_align_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lsu_align_unit_if.sv
// Bus bundle between the EX/MEM pipeline register, the alignment unit and data_memory.
// The slave side is the alignment unit; the master side is the pipeline plus memory.
interface lsu_align_unit_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     req_valid_e;
  logic                     mem_read_e;
  logic                     mem_write_e;
  logic [2:0]               funct3_e;
  logic [ADDRESS_WIDTH-1:0] addr_e;
  logic [DATA_WIDTH-1:0]    write_data_e;
  logic                     stall_lsu;
  logic                     load_valid_m;
  logic [DATA_WIDTH-1:0]    load_data_m;
  logic                     dm_mem_write;
  logic [2:0]               dm_funct3;
  logic [ADDRESS_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0]    dm_write_data;
  logic [DATA_WIDTH-1:0]    dm_read_data;

  modport slave (
    input  req_valid_e, mem_read_e, mem_write_e, funct3_e, addr_e, write_data_e, dm_read_data,
    output stall_lsu, load_valid_m, load_data_m, dm_mem_write, dm_funct3, dm_addr, dm_write_data
  );

  modport master (
    output req_valid_e, mem_read_e, mem_write_e, funct3_e, addr_e, write_data_e, dm_read_data,
    input  stall_lsu, load_valid_m, load_data_m, dm_mem_write, dm_funct3, dm_addr, dm_write_data
  );
endinterface

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: aligned accesses pass through, misaligned loads become two
// word reads merged together, misaligned stores become a burst of byte stores.
module lsu_align_unit #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_align_unit_if.slave   bus
);
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      k_q, k_d;

  logic            req, is_wr, is_rd, misal, unsup;
  logic [DW-1:0]   merged;

  // A request is never accepted while reset is held, so an abort issues no further writes.
  assign req   = bus.req_valid_e & rst_n;
  assign is_wr = req & bus.mem_write_e;
  assign is_rd = req & bus.mem_read_e & ~bus.mem_write_e;
  assign unsup = (bus.funct3_e == 3'b011) || (bus.funct3_e == 3'b110) || (bus.funct3_e == 3'b111);
  assign merged = DW'({bus.dm_read_data, lo_q} >> {off_q, 3'b000});

  always_comb begin
    case (bus.funct3_e)
      F3_LW:         misal = |bus.addr_e[1:0];
      F3_LH, F3_LHU: misal = bus.addr_e[0];
      default:       misal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    f3_d    = f3_q;
    off_d   = off_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    k_d     = k_q;

    bus.dm_mem_write  = 1'b0;
    bus.dm_funct3     = bus.funct3_e;
    bus.dm_addr       = bus.addr_e;
    bus.dm_write_data = bus.write_data_e;
    bus.stall_lsu     = 1'b0;
    bus.load_valid_m  = 1'b0;
    bus.load_data_m   = '0;

    case (state_q)
      IDLE: begin
        if (req && unsup) begin
          // unsupported width code: no access, outputs stay at defaults
        end else if (is_wr && misal) begin
          addr_d            = bus.addr_e;
          data_d            = bus.write_data_e;
          last_d            = (bus.funct3_e == F3_LW) ? 2'd3 : 2'd1;
          k_d               = 2'd1;
          bus.dm_mem_write  = 1'b1;
          bus.dm_funct3     = F3_SB;
          bus.dm_write_data = DW'(bus.write_data_e[7:0]);
          bus.stall_lsu     = 1'b1;
          state_d           = ST_BYTE;
        end else if (is_rd && misal) begin
          lo_d          = bus.dm_read_data;
          f3_d          = bus.funct3_e;
          off_d         = bus.addr_e[1:0];
          base_d        = {bus.addr_e[AW-1:2], 2'b00};
          bus.dm_funct3 = F3_LW;
          bus.dm_addr   = {bus.addr_e[AW-1:2], 2'b00};
          bus.stall_lsu = 1'b1;
          state_d       = LD_HI;
        end else begin
          bus.dm_mem_write = is_wr;
          if (is_rd) begin
            bus.load_valid_m = 1'b1;
            bus.load_data_m  = bus.dm_read_data;
          end
        end
      end

      LD_HI: begin
        bus.dm_funct3     = F3_LW;
        bus.dm_addr       = base_q + AW'(4);
        bus.dm_write_data = '0;
        bus.load_valid_m  = 1'b1;
        case (f3_q)
          F3_LW:   bus.load_data_m = merged;
          F3_LH:   bus.load_data_m = {{(DW-16){merged[15]}}, merged[15:0]};
          default: bus.load_data_m = {{(DW-16){1'b0}}, merged[15:0]};
        endcase
        state_d = IDLE;
      end

      ST_BYTE: begin
        bus.dm_mem_write  = 1'b1;
        bus.dm_funct3     = F3_SB;
        bus.dm_addr       = addr_q + AW'(k_q);
        bus.dm_write_data = DW'(data_q[{k_q, 3'b000} +: 8]);
        bus.stall_lsu     = (k_q != last_q);
        if (k_q == last_q) begin
          k_d     = 2'd0;
          state_d = IDLE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule
